gcm_auth_engine: RTL

GCM_AUTH_ENGINE -- requirements
Module: gcm_auth_engine

---
 rtl/gcm_pkg.sv | 29 ++
 rtl/gf128_mul_ds.sv | 80 ++++++++
 rtl/gcm_auth_engine.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/gcm_pkg.sv
// Shared constants, state encoding and helpers for the GCM tag engine.
// Bit order: vectors are [0:127]; bit 0 is the MSB of byte 0 (x^0).
package gcm_pkg;

    localparam int LEN_W = 64;

    // x^128 + x^7 + x^2 + x + 1 in bit-reflected form.
    localparam logic [0:127] GCM_R = {8'hE1, 120'd0};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_MULT,
        S_LEN,
        S_FINAL,
        S_DONE
    } state_t;

    // Keep bytes 0..n-1, zero the rest.
    function automatic logic [0:127] byte_mask(input int n);
        logic [0:127] m;
        m = '0;
        for (int i = 0; i < 16; i++) begin
            m[i*8 +: 8] = (i < n) ? 8'hFF : 8'h00;
        end
        return m;
    endfunction

endpackage

// File: rtl/gf128_mul_ds.sv
// Digit-serial GF(2^128) multiplier, GCM bit order, DIGIT bits per cycle.
// Ports: iClk, iRstn (sync, active-low), i_start loads i_a (X) and i_b (Y),
//   i_abort drops the operation; o_done is high in the final step cycle,
//   with o_z carrying X*Y in that same cycle.
module gf128_mul_ds
    import gcm_pkg::*;
#(
    parameter int DIGIT = 8
) (
    input  logic         iClk,
    input  logic         iRstn,
    input  logic         i_start,
    input  logic         i_abort,
    input  logic [0:127] i_a,
    input  logic [0:127] i_b,
    output logic         o_done,
    output logic [0:127] o_z
);

    localparam int STEPS = 128 / DIGIT;

    logic [0:127] r_z;
    logic [0:127] r_v;
    logic [0:127] r_x;
    logic [7:0]   r_cnt;
    logic         r_busy;

    logic [0:127] w_z;
    logic [0:127] w_v;
    logic         w_last;

    // DIGIT iterations of the shift-and-add loop, consuming r_x[0..DIGIT-1].
    always_comb begin
        w_z = r_z;
        w_v = r_v;
        for (int d = 0; d < DIGIT; d++) begin
            if (r_x[d]) begin
                w_z = w_z ^ w_v;
            end
            if (w_v[127]) begin
                w_v = (w_v >> 1) ^ GCM_R;
            end else begin
                w_v = w_v >> 1;
            end
        end
    end

    assign w_last = r_busy && (r_cnt == 8'(STEPS - 1));
    assign o_done = w_last;
    assign o_z    = w_z;

    always_ff @(posedge iClk) begin
        if (!iRstn || i_abort) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
        end else if (r_busy) begin
            r_cnt <= r_cnt + 8'd1;
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Operand registers need no reset: only read while r_busy.
    always_ff @(posedge iClk) begin
        if (i_start) begin
            r_z <= '0;
            r_v <= i_b;
            r_x <= i_a;
        end else if (r_busy) begin
            r_z <= w_z;
            r_v <= w_v;
            r_x <= r_x << DIGIT;
        end
    end

endmodule

// File: rtl/gcm_auth_engine.sv
// GHASH + tag engine for AES-GCM. Macro GCM_AUTH_TAG_CHECK_EN adds tag compare.
// Ports: iClk, iRstn (sync, active-low), iInit, H/EkY0/iTag with load strobes,
//   iData beat (valid/type/last/bytes) with oReady, oTag/oTag_valid/oAuthentic/oErr.
module gcm_auth_engine
    import gcm_pkg::*;
#(
    parameter int DIGIT     = 8,
    parameter int TAG_BYTES = 16
) (
    input  logic         iClk,
    input  logic         iRstn,
    input  logic         iInit,
    input  logic [0:127] iHashKey,
    input  logic         iHashKey_valid,
    input  logic [0:127] iEkY0,
    input  logic         iEkY0_valid,
    input  logic [0:127] iData,
    input  logic         iData_valid,
    input  logic         iData_type,
    input  logic         iData_last,
    input  logic [4:0]   iData_bytes,
    output logic         oReady,
    input  logic [0:127] iTag,
    input  logic         iTag_valid,
    output logic [0:127] oTag,
    output logic         oTag_valid,
    output logic         oAuthentic,
    output logic         oErr
);

    localparam logic [0:127] TAG_MASK = byte_mask(TAG_BYTES);

    state_t r_state;
    state_t w_next;

    logic [0:127]     r_acc;
    logic [0:127]     r_h;
    logic [0:127]     r_ek;
    logic [0:127]     r_tag;
    logic [LEN_W-1:0] r_len_aad;
    logic [LEN_W-1:0] r_len_txt;
    logic             r_last;
    logic             r_seen_txt;
    logic             r_err;

    logic [0:127]     w_blk;
    logic [0:127]     w_lens;
    logic [0:127]     w_tag;
    logic [0:127]     w_mul_a;
    logic [0:127]     w_mul_z;
    logic [LEN_W-1:0] w_bits;
    logic             w_accept;
    logic             w_empty;
    logic             w_beat_err;
    logic             w_mul_start;
    logic             w_mul_done;
    logic             w_mul_st;

    // iInit wins over a beat offered in the same cycle.
    assign w_accept = iData_valid && oReady && !iInit;
    assign w_empty  = (iData_bytes == 5'd0);
    assign w_blk    = iData & byte_mask(int'(iData_bytes));
    assign w_lens   = {r_len_aad, r_len_txt};
    assign w_bits   = LEN_W'({iData_bytes, 3'b000});
    assign w_tag    = (r_acc ^ r_ek) & TAG_MASK;
    assign w_mul_st = (r_state == S_MULT) || (r_state == S_LEN);

    assign w_beat_err =
        (w_empty && !iData_last) ||
        (!w_empty && !iData_last && (iData_bytes < 5'd16)) ||
        (!w_empty && !iData_type && r_seen_txt);

    // Start a multiply on a data beat, on an empty terminator (length
    // block only), or back-to-back from the last data block into LEN.
    always_comb begin
        w_mul_start = 1'b0;
        w_mul_a     = r_acc;
        if (w_accept && !w_empty) begin
            w_mul_start = 1'b1;
            w_mul_a     = r_acc ^ w_blk;
        end else if (w_accept && iData_last) begin
            w_mul_start = 1'b1;
            w_mul_a     = r_acc ^ w_lens;
        end else if (r_state == S_MULT && w_mul_done && r_last) begin
            w_mul_start = 1'b1;
            w_mul_a     = w_mul_z ^ w_lens;
        end
    end

    gf128_mul_ds #(
        .DIGIT(DIGIT)
    ) u_mul (
        .iClk   (iClk),
        .iRstn  (iRstn),
        .i_start(w_mul_start),
        .i_abort(iInit),
        .i_a    (w_mul_a),
        .i_b    (r_h),
        .o_done (w_mul_done),
        .o_z    (w_mul_z)
    );

    always_ff @(posedge iClk) begin
        if (!iRstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (iInit) begin
            w_next = S_ACCEPT;
        end else begin
            unique case (r_state)
                S_IDLE:   w_next = S_IDLE;
                S_ACCEPT: begin
                    if (w_accept && !w_empty) begin
                        w_next = S_MULT;
                    end else if (w_accept && iData_last) begin
                        w_next = S_LEN;
                    end
                end
                S_MULT: begin
                    if (w_mul_done) begin
                        w_next = r_last ? S_LEN : S_ACCEPT;
                    end
                end
                S_LEN: begin
                    if (w_mul_done) begin
                        w_next = S_FINAL;
                    end
                end
                S_FINAL:  w_next = S_DONE;
                S_DONE:   w_next = S_IDLE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        oReady     = (r_state == S_ACCEPT);
        oTag_valid = (r_state == S_DONE);
        oTag       = r_tag;
        oErr       = r_err;
    end

    always_ff @(posedge iClk) begin
        if (!iRstn || iInit) begin
            r_acc      <= '0;
            r_len_aad  <= '0;
            r_len_txt  <= '0;
            r_last     <= 1'b0;
            r_seen_txt <= 1'b0;
            r_err      <= 1'b0;
            r_tag      <= '0;
        end else begin
            if (w_accept) begin
                r_last <= iData_last;
                if (w_beat_err) begin
                    r_err <= 1'b1;
                end
                if (!w_empty && iData_type) begin
                    r_seen_txt <= 1'b1;
                    r_len_txt  <= r_len_txt + w_bits;
                end
                if (!w_empty && !iData_type) begin
                    r_len_aad <= r_len_aad + w_bits;
                end
            end
            if (w_mul_st && w_mul_done) begin
                r_acc <= w_mul_z;
            end
            if (r_state == S_FINAL) begin
                r_tag <= w_tag;
            end
        end
    end

    // Key material survives reset.
    always_ff @(posedge iClk) begin
        if (iHashKey_valid) begin
            r_h <= iHashKey;
        end
        if (iEkY0_valid) begin
            r_ek <= iEkY0;
        end
    end

`ifdef GCM_AUTH_TAG_CHECK_EN
    logic [0:127] r_exp;
    logic         r_auth;

    always_ff @(posedge iClk) begin
        if (iTag_valid) begin
            r_exp <= iTag;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRstn || iInit) begin
            r_auth <= 1'b0;
        end else if (r_state == S_FINAL) begin
            r_auth <= (w_tag == (r_exp & TAG_MASK));
        end
    end

    assign oAuthentic = r_auth;
`else
    logic w_unused_tag;
    assign w_unused_tag = ^{iTag, iTag_valid};
    assign oAuthentic   = 1'b0;
`endif

endmodule
